// File: rtl/rx_lbuf_sched.sv
// rx_lbuf_sched: receive-side large-buffer scheduler.
//
// Hands the two host buffers to the RX DMA write engine in strict ping-pong
// order (buffer 1, buffer 2, buffer 1, ...). Byte ranges inside the active
// buffer are allocated per write request. A buffer is closed when it is
// exactly full, when a request does not fit, or on flush. Each close raises a
// one-cycle lbufN_dn pulse with the used byte count on dn_bytes.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   lbufN_addr/lbufN_en  host buffer base (size-aligned) and ownership level
//   lbufN_dn             buffer N closed (one-cycle pulse)
//   wr_req/wr_len        space request from the DMA engine (level, held to gnt)
//   wr_gnt/wr_addr       grant pulse and host address of the granted range
//   flush                pulse: close the current buffer if non-empty
//   dn_bytes             bytes used in the buffer just closed
//   cur_sel              0 = buffer 1, 1 = buffer 2 is current/next
//   active               a buffer is currently held
module rx_lbuf_sched #(
  parameter int SZ_LOG2 = 20,
  parameter int LEN_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        lbuf1_addr,
  input  logic               lbuf1_en,
  output logic               lbuf1_dn,
  input  logic [63:0]        lbuf2_addr,
  input  logic               lbuf2_en,
  output logic               lbuf2_dn,
  input  logic               wr_req,
  input  logic [LEN_W-1:0]   wr_len,
  output logic               wr_gnt,
  output logic [63:0]        wr_addr,
  input  logic               flush,
  output logic [SZ_LOG2:0]   dn_bytes,
  output logic               cur_sel,
  output logic               active
);

  // One bit of headroom above the offset so offset+len never overflows.
  localparam int SW = SZ_LOG2 + 2;
  localparam logic [SZ_LOG2:0] FULL_OFF = {1'b1, {SZ_LOG2{1'b0}}};
  localparam logic [SW-1:0]    FULL_SUM = {2'b01, {SZ_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_WAIT,
    S_ACTIVE,
    S_GNT,
    S_CLOSE
  } state_t;

  state_t               state_q, state_d;
  logic                 cur_sel_q, cur_sel_d;
  logic [63:SZ_LOG2]    base_q, base_d;
  logic [SZ_LOG2:0]     offset_q, offset_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [63:0]          wr_addr_q, wr_addr_d;
  logic [SZ_LOG2:0]     dn_bytes_q, dn_bytes_d;

  logic                 sel_en;
  logic [63:0]          sel_addr;
  logic [SW-1:0]        sum;
  logic                 fits;

  // Buffer bases are size-aligned, so their low bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lbuf1_addr[SZ_LOG2-1:0], lbuf2_addr[SZ_LOG2-1:0]};

  // Only the buffer next in ping-pong order is ever looked at.
  assign sel_en   = cur_sel_q ? lbuf2_en   : lbuf1_en;
  assign sel_addr = cur_sel_q ? lbuf2_addr : lbuf1_addr;

  assign sum  = {1'b0, offset_q} + SW'(wr_len);
  assign fits = (sum <= FULL_SUM);

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    base_d       = base_q;
    offset_d     = offset_q;
    // A flush is remembered in every state; CLOSE overrides this below.
    flush_pend_d = flush_pend_q | flush;
    wr_addr_d    = wr_addr_q;
    dn_bytes_d   = dn_bytes_q;

    case (state_q)
      S_WAIT: begin
        if (sel_en) begin
          base_d   = sel_addr[63:SZ_LOG2];
          offset_d = '0;
          state_d  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (wr_req && fits) begin
          // Length is consumed here, so wr_len may change once wr_gnt is seen.
          wr_addr_d = {base_q, offset_q[SZ_LOG2-1:0]};
          offset_d  = sum[SZ_LOG2:0];
          state_d   = S_GNT;
        end else if (wr_req) begin
          // Request stays pending and is served from the next buffer.
          dn_bytes_d = offset_q;
          state_d    = S_CLOSE;
        end else if (flush_pend_q && (offset_q != '0)) begin
          dn_bytes_d = offset_q;
          state_d    = S_CLOSE;
        end else if (flush_pend_q) begin
          // Nothing to flush in an empty buffer; a new flush still registers.
          flush_pend_d = flush;
        end
      end
      S_GNT: begin
        if (offset_q == FULL_OFF) begin
          dn_bytes_d = offset_q;
          state_d    = S_CLOSE;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_CLOSE: begin
        flush_pend_d = 1'b0;
        cur_sel_d    = ~cur_sel_q;
        offset_d     = '0;
        state_d      = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      cur_sel_q    <= 1'b0;
      base_q       <= '0;
      offset_q     <= '0;
      flush_pend_q <= 1'b0;
      wr_addr_q    <= '0;
      dn_bytes_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      flush_pend_q <= flush_pend_d;
      wr_addr_q    <= wr_addr_d;
      dn_bytes_q   <= dn_bytes_d;
    end
  end

  // All outputs decode directly from registers.
  assign wr_gnt   = (state_q == S_GNT);
  assign lbuf1_dn = (state_q == S_CLOSE) && !cur_sel_q;
  assign lbuf2_dn = (state_q == S_CLOSE) &&  cur_sel_q;
  assign active   = (state_q == S_ACTIVE) || (state_q == S_GNT);
  assign wr_addr  = wr_addr_q;
  assign dn_bytes = dn_bytes_q;
  assign cur_sel  = cur_sel_q;

endmodule

// File: tb/tb_rx_lbuf_sched.sv
`timescale 1ns/1ps
module tb_rx_lbuf_sched;

  localparam int SZ = 12;
  localparam int LW = 12;
  localparam int BUF_BYTES = 4096;
  localparam logic [63:0] BASE1 = 64'h1_0000_0000;
  localparam logic [63:0] BASE2 = 64'h2_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   lbuf1_addr = BASE1;
  logic          lbuf1_en = 1'b0;
  logic          lbuf1_dn;
  logic [63:0]   lbuf2_addr = BASE2;
  logic          lbuf2_en = 1'b0;
  logic          lbuf2_dn;
  logic          wr_req = 1'b0;
  logic [LW-1:0] wr_len = '0;
  logic          wr_gnt;
  logic [63:0]   wr_addr;
  logic          flush = 1'b0;
  logic [SZ:0]   dn_bytes;
  logic          cur_sel;
  logic          active;

  always #5 clk = ~clk;

  rx_lbuf_sched #(.SZ_LOG2(SZ), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lbuf1_addr(lbuf1_addr), .lbuf1_en(lbuf1_en), .lbuf1_dn(lbuf1_dn),
    .lbuf2_addr(lbuf2_addr), .lbuf2_en(lbuf2_en), .lbuf2_dn(lbuf2_dn),
    .wr_req(wr_req), .wr_len(wr_len), .wr_gnt(wr_gnt), .wr_addr(wr_addr),
    .flush(flush), .dn_bytes(dn_bytes), .cur_sel(cur_sel), .active(active)
  );

  // Expected output events: kind 0 = grant (val = address),
  // kind 1/2 = buffer 1/2 closed (val = byte count).
  typedef struct {
    int          kind;
    logic [63:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: which buffer is current and how many bytes it holds.
  int          m_cur = 0;
  int          m_off = 0;
  logic [63:0] m_base [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic model_close();
    push(m_cur + 1, 64'(m_off));
    m_cur = 1 - m_cur;
    m_off = 0;
  endtask

  task automatic model_req(input int len);
    if (m_off + len > BUF_BYTES) model_close();
    push(0, m_base[m_cur] + 64'(m_off));
    m_off = m_off + len;
    if (m_off == BUF_BYTES) model_close();
  endtask

  task automatic model_flush();
    if (m_off != 0) model_close();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the grant of the request currently driven; flush is a pulse so
  // it is always dropped after the first edge.
  task automatic wait_gnt(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (wr_gnt) begin
        got = 1'b1;
        break;
      end
    end
    wr_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: got no wr_gnt expected wr_gnt within 60 cycles", name);
    end
  endtask

  task automatic do_req(input int len);
    model_req(len);
    wr_len = LW'(len);
    wr_req = 1'b1;
    wait_gnt("gnt_timeout");
  endtask

  task automatic do_flush();
    model_flush();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(6);
  endtask

  // Monitor: every grant and every close must match the next expected event.
  ev_t ev;
  logic prev_gnt = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_gnt) begin
        check("gnt_spacing", 64'(prev_gnt), 64'd0);
        $display("grant addr=0x%0h", wr_addr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got addr 0x%0h expected none", wr_addr);
        end else begin
          ev = exp_q.pop_front();
          check("gnt_kind", 64'd0, 64'(ev.kind));
          check("gnt_addr", wr_addr, ev.val);
        end
      end
      if (lbuf1_dn || lbuf2_dn) begin
        $display("close buf=%0d dn_bytes=%0d", lbuf2_dn ? 2 : 1, dn_bytes);
        check("dn_single", {62'd0, lbuf2_dn, lbuf1_dn} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dn: got buf %0d bytes %0d expected none",
                   lbuf2_dn ? 2 : 1, dn_bytes);
        end else begin
          ev = exp_q.pop_front();
          check("dn_buf", lbuf2_dn ? 64'd2 : 64'd1, 64'(ev.kind));
          check("dn_bytes", 64'(dn_bytes), ev.val);
        end
      end
    end
    prev_gnt = wr_gnt & rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int len;
    bit got;
    m_base[0] = BASE1;
    m_base[1] = BASE2;

    // Reset values.
    idle(3);
    check("rst_wr_gnt",   64'(wr_gnt), 64'd0);
    check("rst_wr_addr",  wr_addr, 64'd0);
    check("rst_dn1",      64'(lbuf1_dn), 64'd0);
    check("rst_dn2",      64'(lbuf2_dn), 64'd0);
    check("rst_dn_bytes", 64'(dn_bytes), 64'd0);
    check("rst_cur_sel",  64'(cur_sel), 64'd0);
    check("rst_active",   64'(active), 64'd0);
    rst_n = 1'b1;

    // Buffer 2 owned first: nothing happens until buffer 1 arrives.
    lbuf2_en = 1'b1;
    model_req(1024);
    wr_len = LW'(1024);
    wr_req = 1'b1;
    idle(10);
    check("buf2_first_active", 64'(active), 64'd0);
    check("buf2_first_sel",    64'(cur_sel), 64'd0);
    lbuf1_en = 1'b1;
    wait_gnt("first_gnt");

    // Fill buffer 1 exactly.
    do_req(1024);
    do_req(1024);
    do_req(1024);
    idle(4);
    check("full_dn_bytes", 64'(dn_bytes), 64'd4096);
    check("full_cur_sel",  64'(cur_sel), 64'd1);

    // Non-fit in buffer 2; request waits for buffer 1 to be re-owned.
    do_req(3000);
    lbuf1_en = 1'b0;
    model_req(1200);
    wr_len = LW'(1200);
    wr_req = 1'b1;
    idle(10);
    check("nofit_active",   64'(active), 64'd0);
    check("nofit_cur_sel",  64'(cur_sel), 64'd0);
    check("nofit_dn_bytes", 64'(dn_bytes), 64'd3000);
    lbuf1_en = 1'b1;
    wait_gnt("nofit_gnt");

    // Flushes: non-empty, non-empty, empty.
    do_flush();
    check("flush1_dn_bytes", 64'(dn_bytes), 64'd1200);
    check("flush1_cur_sel",  64'(cur_sel), 64'd1);
    do_req(512);
    do_flush();
    check("flush2_dn_bytes", 64'(dn_bytes), 64'd512);
    do_flush();
    check("flush_empty_active", 64'(active), 64'd1);
    check("flush_empty_sel",    64'(cur_sel), 64'd0);

    // Zero-length request together with flush.
    do_req(64);
    model_req(0);
    model_flush();
    wr_len = '0;
    wr_req = 1'b1;
    flush  = 1'b1;
    wait_gnt("zero_len_gnt");
    idle(6);
    check("zero_len_dn_bytes", 64'(dn_bytes), 64'd64);
    check("zero_len_cur_sel",  64'(cur_sel), 64'd1);

    // Randomized traffic with both buffers owned.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_flush();
      end else begin
        if (r == 1 && (BUF_BYTES - m_off) <= 4088) len = BUF_BYTES - m_off;
        else if (r == 2) len = 4088;
        else len = 8 * int'($urandom_range(0, 511));
        do_req(len);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(8);

    // Reset in the middle of a grant.
    wr_len = LW'(8);
    wr_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (wr_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check("rstgnt_seen", 64'(got), 64'd1);
    rst_n = 1'b0;
    #1;
    wr_req = 1'b0;
    check("rstgnt_wr_gnt",   64'(wr_gnt), 64'd0);
    check("rstgnt_wr_addr",  wr_addr, 64'd0);
    check("rstgnt_dn",       64'({lbuf2_dn, lbuf1_dn}), 64'd0);
    check("rstgnt_dn_bytes", 64'(dn_bytes), 64'd0);
    check("rstgnt_cur_sel",  64'(cur_sel), 64'd0);
    check("rstgnt_active",   64'(active), 64'd0);
    m_cur = 0;
    m_off = 0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_active", 64'(active), 64'd1);
    check("post_rst_sel",    64'(cur_sel), 64'd0);
    do_req(8);
    idle(10);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
